// File: rtl/task8_seq.sv
// Sample sequencer for the task_8 accumulate datapath: buffers a vector of
// samples, then chains them through one datapath instance with a watchdog.
module task8_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    input  logic                    go,
    input  logic [DATA_W-1:0]       sum_init,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [DATA_W-1:0]       result,
    output logic                    dp_start,
    output logic [DATA_W-1:0]       dp_x,
    output logic [DATA_W-1:0]       dp_sum,
    input  logic                    dp_done,
    input  logic [DATA_W-1:0]       dp_new_sum
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_nxt;
    logic                full_q;
    logic [TW-1:0]       wdog;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   head;
    logic                dp_start_q;
    logic                done_q;
    logic                busy_q;
    logic                error_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   dp_x_q;
    logic [DATA_W-1:0]   dp_sum_q;
    logic                push;
    logic                push_ok;
    logic                pop;
    logic                timeout_hit;

    // Pulses are masked while the global enable is low so a held register
    // never looks like a fresh start/done to the neighbours.
    assign dp_start = dp_start_q & clk_en;
    assign done     = done_q & clk_en;
    assign full     = full_q;
    assign level    = level_q;
    assign busy     = busy_q;
    assign error    = error_q;
    assign result   = result_q;
    assign dp_x     = dp_x_q;
    assign dp_sum   = dp_sum_q;

    assign push        = wr_en & clk_en & ~full_q;
    assign pop         = clk_en & (state == ISSUE);
    assign timeout_hit = clk_en & (state == WAIT) & ~dp_done & (wdog == TW'(TIMEOUT - 1));
    // A timeout flushes the queue; a write landing in that same cycle goes with it.
    assign push_ok     = push & ~timeout_hit;
    assign head        = mem[rd_ptr];

    // Next occupancy
    always_comb begin
        level_nxt = level_q;
        if (timeout_hit) begin
            level_nxt = '0;
        end else begin
            level_nxt = level_q + LW'(push_ok) - LW'(pop);
        end
    end

    // FIFO pointers and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (timeout_hit) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_nxt;
            full_q  <= (level_nxt == LW'(DEPTH));
        end
    end

    // Sample storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wdog       <= '0;
            acc        <= '0;
            dp_start_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            dp_x_q     <= '0;
            dp_sum_q   <= '0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (go) begin
                        acc     <= sum_init;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (level_q == '0) begin
                            state <= FINISH;
                        end else begin
                            state      <= ISSUE;
                            dp_start_q <= 1'b1;
                            dp_x_q     <= head;
                            dp_sum_q   <= sum_init;
                        end
                    end
                end
                ISSUE: begin
                    dp_start_q <= 1'b0;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        acc <= dp_new_sum;
                        if (level_q == '0) begin
                            state <= FINISH;
                        end else begin
                            state      <= ISSUE;
                            dp_start_q <= 1'b1;
                            dp_x_q     <= head;
                            dp_sum_q   <= dp_new_sum;
                        end
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state   <= FINISH;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                FINISH: begin
                    result_q <= acc;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task8_seq.sv
// Scoreboard bench for task8_seq with a 4-cycle integer-add datapath stand-in.
module tb_task8_seq;

    localparam int DEPTH = 16;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        clk_en     = 1'b1;
    logic        wr_en      = 1'b0;
    logic [31:0] wr_data    = '0;
    logic        go         = 1'b0;
    logic [31:0] sum_init   = '0;
    logic        dp_done    = 1'b0;
    logic [31:0] dp_new_sum = '0;
    logic        full;
    logic [4:0]  level;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic        dp_start;
    logic [31:0] dp_x;
    logic [31:0] dp_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_done   = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int go_cyc    = 0;
    int run_start0 = 0;
    int run_done0  = 0;

    logic [31:0] sw_q[$];
    logic [31:0] exp_x_q[$];
    logic [31:0] exp_sum_q[$];
    logic [31:0] exp_res_q[$];
    bit          exp_err_q[$];

    bit          dp_hang = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_sum   = '0;

    task8_seq #(.DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .level      (level),
        .go         (go),
        .sum_init   (sum_init),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .result     (result),
        .dp_start   (dp_start),
        .dp_x       (dp_x),
        .dp_sum     (dp_sum),
        .dp_done    (dp_done),
        .dp_new_sum (dp_new_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: not reset with the sequencer, stalls with clk_en
    always @(posedge clk) begin
        if (clk_en) begin
            dp_done <= 1'b0;
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt      <= 0;
                dp_done    <= 1'b1;
                dp_new_sum <= m_sum;
            end
            if (dp_start && !dp_hang) begin
                m_cnt <= 3;
                m_sum <= dp_sum + dp_x;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop expectations as the DUT produces starts and dones
    always @(negedge clk) begin
        if (reset) begin
            if (dp_start) begin
                n_start++;
                start_cyc = cyc;
                if (exp_x_q.size() == 0) begin
                    check("unexpected_dp_start", 32'(dp_start), 32'd0);
                end else begin
                    check("dp_x", dp_x, exp_x_q.pop_front());
                    check("dp_sum", dp_sum, exp_sum_q.pop_front());
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (exp_res_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    check("result", result, exp_res_q.pop_front());
                    check("error_at_done", 32'(error), 32'(exp_err_q.pop_front()));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        if (sw_q.size() < DEPTH) sw_q.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic launch(input logic [31:0] init, input bit hang);
        logic [31:0] acc;
        acc = init;
        if (hang) begin
            exp_x_q.push_back(sw_q[0]);
            exp_sum_q.push_back(init);
            exp_err_q.push_back(1'b1);
        end else begin
            foreach (sw_q[i]) begin
                exp_x_q.push_back(sw_q[i]);
                exp_sum_q.push_back(acc);
                acc = acc + sw_q[i];
            end
            exp_err_q.push_back(1'b0);
        end
        exp_res_q.push_back(acc);
        sw_q.delete();
        run_start0 = n_start;
        run_done0  = n_done;
        go_cyc     = cyc;
        go         = 1'b1;
        sum_init   = init;
        tick();
        go = 1'b0;
    endtask

    task automatic finish_wait;
        for (int i = 0; i < 400 && n_done == run_done0; i++) tick();
        check("done_pulse", 32'(n_done - run_done0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_dp_start"}, 32'(dp_start), 32'd0);
        check({tag, "_dp_x"}, dp_x, 32'd0);
        check({tag, "_dp_sum"}, dp_sum, 32'd0);
    endtask

    initial begin
        int n0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // single sample
        push_word(32'h43480000);
        launch(32'h470490FB, 1'b0);
        finish_wait();
        check("go_to_start", 32'(start_cyc - go_cyc), 32'd1);
        check("start_to_done", 32'(done_cyc - start_cyc), 32'd6);
        check("single_result", result, 32'h8A4C90FB);
        check("busy_after_done", 32'(busy), 32'd0);

        // chaining two samples
        push_word(32'h43480000);
        push_word(32'h43800000);
        launch(32'h0, 1'b0);
        finish_wait();
        check("chain_starts", 32'(n_start - run_start0), 32'd2);
        check("chain_result", result, 32'h86C80000);

        // empty run
        launch(32'h12345678, 1'b0);
        finish_wait();
        check("empty_latency", 32'(done_cyc - go_cyc), 32'd2);
        check("empty_no_start", 32'(n_start - run_start0), 32'd0);
        check("empty_result", result, 32'h12345678);

        // overflow: 17 pushes, last dropped
        for (int w = 1; w <= 17; w++) push_word(32'(w));
        check("full_flag", 32'(full), 32'd1);
        check("full_level", 32'(level), 32'd16);
        launch(32'h0, 1'b0);
        finish_wait();
        check("overflow_result", result, 32'd136);
        check("drain_level", 32'(level), 32'd0);
        check("drain_full", 32'(full), 32'd0);

        // clk_en stall in WAIT
        push_word(32'h00000777);
        launch(32'h00001000, 1'b0);
        tick();
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_dp_start", 32'(dp_start), 32'd0);
            tick();
        end
        clk_en = 1'b1;
        finish_wait();
        check("stall_latency", 32'(done_cyc - start_cyc), 32'd11);

        // watchdog timeout with a hung datapath
        dp_hang = 1'b1;
        push_word(32'h0000000A);
        push_word(32'h0000000B);
        push_word(32'h0000000C);
        launch(32'h00000055, 1'b1);
        finish_wait();
        check("timeout_latency", 32'(done_cyc - start_cyc), 32'd66);
        check("timeout_starts", 32'(n_start - run_start0), 32'd1);
        check("timeout_level", 32'(level), 32'd0);
        tick();
        tick();
        check("error_sticky", 32'(error), 32'd1);
        dp_hang = 1'b0;
        push_word(32'h00000009);
        launch(32'h00000001, 1'b0);
        finish_wait();
        check("error_cleared", 32'(error), 32'd0);

        // async reset mid-WAIT, late dp_done must be ignored
        push_word(32'h00000011);
        launch(32'h00000022, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_res_q.delete();
        exp_err_q.delete();
        exp_x_q.delete();
        exp_sum_q.delete();
        n0 = n_done;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check("late_done_ignored", 32'(n_done - n0), 32'd0);
        check("late_busy", 32'(busy), 32'd0);
        check("late_result", result, 32'd0);
        push_word(32'h00000005);
        launch(32'h00000007, 1'b0);
        finish_wait();
        check("post_reset_result", result, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
